adc_serial_multi: RTL

ADC_SERIAL_MULTI -- requirements
Module: adc_serial_multi

---
 rtl/adc_serial_multi.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/adc_serial_multi.sv
// adc_serial_multi: reads NUM_CH serial ADCs that share one SCLK and one CS_N.
// Each frame: CS_N low, LEAD_CLKS blank SCLK periods, DATA_W data periods
// (MSB first, sampled on SCLK rising edges), then IDLE_CLKS periods of CS_N high.
// Completed sample sets are presented on a valid/ready output register with a
// sticky overrun flag for sets dropped while the output is still occupied.
//
// Build option: define ADC_SERIAL_MULTI_PEAK_HOLD_EN to add per-channel peak hold
// registers; without it the peak port drives constant zero.
//
// state | meaning
// IDLE  | CS_N high, SCLK low, waiting for enable
// CONV  | CS_N low, SCLK toggling, shifting in lead + data bits
// QUIET | CS_N high between frames, then CONV (enable) or IDLE
module adc_serial_multi #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 12,
    parameter int LEAD_CLKS = 2,
    parameter int CLK_DIV   = 2,
    parameter int IDLE_CLKS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic                     adc_sclk,
    output logic                     adc_cs_n,
    input  logic [NUM_CH-1:0]        adc_sd,
    output logic [NUM_CH*DATA_W-1:0] data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     overrun,
    input  logic                     overrun_clr,
    output logic [NUM_CH*DATA_W-1:0] peak,
    input  logic                     peak_clr
);

    localparam int SW = NUM_CH * DATA_W;
    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic [4:0] PER_LAST   = 5'(LEAD_CLKS + DATA_W - 1);
    localparam logic [4:0] DATA_BITS  = 5'(DATA_W);
    localparam logic [8:0] QUIET_LAST = 9'(IDLE_CLKS * 2 * CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     div_q, div_d;       // clk cycles left in the current SCLK half-period
    logic           sclk_q, sclk_d;
    logic [4:0]     per_q, per_d;       // SCLK periods left after the current one
    logic [8:0]     quiet_q, quiet_d;   // clk cycles left with CS_N high
    logic           sample_en;
    logic           conv_exit;
    logic           done_q;             // one cycle after CONV exits: sample set ready
    logic [SW-1:0]  shift_q;
    logic [SW-1:0]  data_q;
    logic           valid_q;
    logic           overrun_q;
    logic           occupied;

    // Next-state and SCLK timing; sampling happens on the clk that raises SCLK.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        per_d     = per_q;
        quiet_d   = quiet_q;
        sample_en = 1'b0;
        conv_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CONV;
                    div_d   = DIV_LAST;
                    sclk_d  = 1'b0;
                    per_d   = PER_LAST;
                end
            end
            CONV: begin
                if (div_q != 4'd0) begin
                    div_d = div_q - 4'd1;
                end else begin
                    div_d = DIV_LAST;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        // Lead edges are counted but their bits are thrown away.
                        sample_en = (per_q < DATA_BITS);
                    end else begin
                        sclk_d = 1'b0;
                        if (per_q == 5'd0) begin
                            conv_exit = 1'b1;
                            state_d   = QUIET;
                            quiet_d   = QUIET_LAST;
                        end else begin
                            per_d = per_q - 5'd1;
                        end
                    end
                end
            end
            QUIET: begin
                if (quiet_q != 9'd0) begin
                    quiet_d = quiet_q - 9'd1;
                end else if (enable) begin
                    state_d = CONV;
                    div_d   = DIV_LAST;
                    sclk_d  = 1'b0;
                    per_d   = PER_LAST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            per_q   <= '0;
            quiet_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            per_q   <= per_d;
            quiet_q <= quiet_d;
            done_q  <= conv_exit;
        end
    end

    // Per-channel shift registers, MSB first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
        end else if (sample_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shift_q[i*DATA_W +: DATA_W] <= {shift_q[i*DATA_W +: DATA_W-1], adc_sd[i]};
            end
        end
    end

    assign occupied = valid_q && !ready;

    // Output register: load a finished set, or drop it while the consumer still holds one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (done_q && !occupied) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            // A drop wins over a simultaneous clear so no lost set goes unreported.
            if (done_q && occupied) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef ADC_SERIAL_MULTI_PEAK_HOLD_EN
    logic [SW-1:0] peak_q, peak_d;

    // Peak update on every completion, dropped sets included; clear + completion restarts at the sample.
    always_comb begin
        peak_d = peak_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (done_q && peak_clr) begin
                peak_d[i*DATA_W +: DATA_W] = shift_q[i*DATA_W +: DATA_W];
            end else if (peak_clr) begin
                peak_d[i*DATA_W +: DATA_W] = '0;
            end else if (done_q && (shift_q[i*DATA_W +: DATA_W] > peak_q[i*DATA_W +: DATA_W])) begin
                peak_d[i*DATA_W +: DATA_W] = shift_q[i*DATA_W +: DATA_W];
            end
        end
    end

    // Peak registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak            = '0;
`endif

    assign adc_sclk = sclk_q;
    assign adc_cs_n = (state_q != CONV);
    assign data     = data_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;

endmodule
